pwm_sample_latch: RTL and testbench

PWM_SAMPLE_LATCH -- requirements
Module: pwm_sample_latch

---
 rtl/pwm_pkg.sv | 8 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/pwm_sample_latch.sv | 106 ++++++++++
 tb/tb_pwm_sample_latch.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM decoder definitions: default sample width and sample type.
package pwm_pkg;

  localparam int unsigned PWM_SAMPLE_W = 8;

  typedef logic signed [PWM_SAMPLE_W-1:0] pwm_sample_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Trigger synchroniser plus rising-edge detector.
//   clk        : sampling clock
//   reset      : async active-high; flops preset to 1 so a high input at release is not an edge
//   async_in   : asynchronous input strobe
//   rise_pulse : registered one-cycle pulse per synchronised 0->1 transition
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift chain, edge history and registered edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q     <= sync_q[SYNC_STAGES-1];
      rise_pulse <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/pwm_sample_latch.sv
// Captures a signed PWM sample on each rising trigger edge into a small FIFO.
//   clk, reset  : clock, async active-high reset
//   trigger_out : async capture strobe (rising edge = one capture)
//   data_in     : signed sample, stable through the capture latency
//   data_out    : head of buffer when data_valid, else last popped value
//   data_valid  : buffer non-empty
//   data_ready  : consumer pops head when data_valid && data_ready
//   level       : entries held, 0..DEPTH
//   overflow    : sticky flag, a capture was dropped on a full buffer
//   clear_ovf   : synchronous overflow clear (a same-cycle drop wins)
module pwm_sample_latch
  import pwm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = PWM_SAMPLE_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         trigger_out,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  input  logic                         data_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  input  logic                         clear_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic                         capture;
  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]                wr_ptr_nxt_c, rd_ptr_nxt_c;
  logic [PW-1:0]                level_nxt_c;
  logic signed [DATA_WIDTH-1:0] head_nxt_c;
  logic [AW-1:0]                wr_idx_c, rd_idx_c, rd_idx_nxt_c;
  logic                         full_c, pop_c, wr_en_c, drop_c;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (trigger_out),
    .rise_pulse (capture)
  );

  assign wr_idx_c     = wr_ptr_q[AW-1:0];
  assign rd_idx_c     = rd_ptr_q[AW-1:0];
  assign rd_idx_nxt_c = rd_ptr_nxt_c[AW-1:0];
  // Same index with differing wrap bits means full.
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx_c == rd_idx_c);
  assign pop_c   = data_valid && data_ready;
  // A same-cycle pop frees the slot, so a full buffer still accepts.
  assign wr_en_c = capture && (!full_c || pop_c);
  assign drop_c  = capture && full_c && !pop_c;

  // Next pointers, level and the head value to present after this edge.
  always_comb begin
    wr_ptr_nxt_c = wr_ptr_q;
    rd_ptr_nxt_c = rd_ptr_q;
    level_nxt_c  = PW'(level);
    head_nxt_c   = data_out;
    if (wr_en_c) wr_ptr_nxt_c = wr_ptr_q + PW'(1);
    if (pop_c)   rd_ptr_nxt_c = rd_ptr_q + PW'(1);
    case ({wr_en_c, pop_c})
      2'b10:   level_nxt_c = PW'(level) + PW'(1);
      2'b01:   level_nxt_c = PW'(level) - PW'(1);
      default: level_nxt_c = PW'(level);
    endcase
    // The new head may be the entry being written this cycle.
    if (level_nxt_c != '0) begin
      if (wr_en_c && (rd_idx_nxt_c == wr_idx_c)) head_nxt_c = data_in;
      else                                       head_nxt_c = mem[rd_idx_nxt_c];
    end
  end

  // Sample storage, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_idx_c] <= data_in;
  end

  // Pointers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level      <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_nxt_c;
      rd_ptr_q   <= rd_ptr_nxt_c;
      level      <= level_nxt_c;
      data_valid <= (level_nxt_c != '0);
      data_out   <= head_nxt_c;
      if (drop_c)         overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_sample_latch.sv
module tb_pwm_sample_latch;

  localparam int unsigned SS  = 2;
  localparam int unsigned SS1 = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trigger_out = 1'b0;
  logic data_ready = 1'b0;
  logic ready1 = 1'b0;
  logic clear_ovf = 1'b0;

  logic signed [7:0]  data_in = '0;
  logic signed [7:0]  data_out;
  logic               data_valid;
  logic [2:0]         level;
  logic               overflow;

  logic signed [11:0] din1 = '0;
  logic signed [11:0] dout1;
  logic               valid1;
  logic [3:0]         level1;
  logic               ovf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_sample_latch u_dut (
    .clk         (clk),
    .reset       (reset),
    .trigger_out (trigger_out),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .level       (level),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
  );

  pwm_sample_latch #(
    .DATA_WIDTH  (12),
    .DEPTH       (8),
    .SYNC_STAGES (SS1)
  ) u_dut_wide (
    .clk         (clk),
    .reset       (reset),
    .trigger_out (trigger_out),
    .data_in     (din1),
    .data_out    (dout1),
    .data_valid  (valid1),
    .data_ready  (ready1),
    .level       (level1),
    .overflow    (ovf1),
    .clear_ovf   (clear_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One trigger pulse; returns just after the edge that writes the sample.
  // pop asserts data_ready only for that write edge.
  task automatic send(input logic signed [7:0] v, input logic signed [11:0] v1,
                      input bit pop, input int unsigned ss);
    data_in = v;
    din1 = v1;
    trigger_out = 1'b1;
    tick();
    tick();
    trigger_out = 1'b0;
    repeat (ss - 1) tick();
    data_ready = pop;
    ready1 = pop;
    tick();
    data_ready = 1'b0;
    ready1 = 1'b0;
  endtask

  task automatic test_reset();
    trigger_out = 1'b1;
    reset = 1'b1;
    tick();
    checks++;
    if (data_out !== 8'sd0 || data_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got out=%0d valid=%b level=%0d ovf=%b exp 0/0/0/0",
               data_out, data_valid, level, overflow);
    end
    reset = 1'b0;
    repeat (8) tick();
    checks++;
    if (level !== 3'd0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_high_trigger got level=%0d valid=%b exp 0/0", level, data_valid);
    end
    trigger_out = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_single();
    int cnt;
    bit found;
    cnt = 0;
    found = 1'b0;
    data_in = -8'sd5;
    trigger_out = 1'b1;
    for (int i = 1; i <= int'(SS) + 3 && !found; i++) begin
      tick();
      if (i == 2) trigger_out = 1'b0;
      if (data_valid === 1'b1) begin
        found = 1'b1;
        cnt = i;
      end
    end
    trigger_out = 1'b0;
    checks++;
    if (!found || cnt < int'(SS) + 1) begin
      failures++;
      $display("FAIL single_latency got found=%b cycles=%0d exp %0d..%0d", found, cnt, SS + 1, SS + 3);
    end
    checks++;
    if (data_out !== -8'sd5 || level !== 3'd1) begin
      failures++;
      $display("FAIL single_value got out=%0d level=%0d exp -5/1", data_out, level);
    end
    tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || data_out !== -8'sd5 || level !== 3'd0) begin
      failures++;
      $display("FAIL single_pop_hold got valid=%b out=%0d level=%0d exp 0/-5/0", data_valid, data_out, level);
    end
    // Pop while empty is ignored.
    data_ready = 1'b1;
    repeat (2) tick();
    data_ready = 1'b0;
    checks++;
    if (level !== 3'd0 || data_out !== -8'sd5) begin
      failures++;
      $display("FAIL empty_pop got level=%0d out=%0d exp 0/-5", level, data_out);
    end
  endtask

  task automatic test_fill_drain();
    logic signed [7:0] e [4];
    e = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    for (int i = 0; i < 4; i++) send(e[i], 12'sd0, 1'b0, SS);
    checks++;
    if (level !== 3'd4 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_level got level=%0d valid=%b exp 4/1", level, data_valid);
    end
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out !== e[i] || data_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_%0d got out=%0d valid=%b exp %0d/1", i, data_out, data_valid, e[i]);
      end
      tick();
    end
    data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'sd4 || level !== 3'd0) begin
      failures++;
      $display("FAIL drain_end got valid=%b out=%0d level=%0d exp 0/4/0", data_valid, data_out, level);
    end
  endtask

  task automatic test_overflow();
    logic signed [7:0] e [4];
    e = '{8'sd10, 8'sd11, 8'sd12, 8'sd13};
    for (int i = 0; i < 4; i++) send(e[i], 12'sd0, 1'b0, SS);
    send(8'sd14, 12'sd0, 1'b0, SS);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got level=%0d ovf=%b exp 4/1", level, overflow);
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got ovf=%b exp 0", overflow);
    end
    // Drop in the same cycle as clear: set wins.
    clear_ovf = 1'b1;
    send(8'sd15, 12'sd0, 1'b0, SS);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins got ovf=%b exp 1", overflow);
    end
    clear_ovf = 1'b0;
    tick();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out !== e[i]) begin
        failures++;
        $display("FAIL ovf_drain_%0d got out=%0d exp %0d", i, data_out, e[i]);
      end
      tick();
    end
    data_ready = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain_end got valid=%b ovf=%b exp 0/0", data_valid, overflow);
    end
  endtask

  task automatic test_full_pop();
    logic signed [7:0] e [4];
    e = '{8'sd22, 8'sd23, 8'sd24, 8'sd25};
    send(8'sd21, 12'sd0, 1'b0, SS);
    for (int i = 0; i < 3; i++) send(e[i], 12'sd0, 1'b0, SS);
    send(8'sd25, 12'sd0, 1'b1, SS);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || data_out !== 8'sd22) begin
      failures++;
      $display("FAIL full_pop got level=%0d ovf=%b head=%0d exp 4/0/22", level, overflow, data_out);
    end
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (data_out !== e[i]) begin
        failures++;
        $display("FAIL full_pop_drain_%0d got out=%0d exp %0d", i, data_out, e[i]);
      end
      tick();
    end
    data_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    send(8'sd40, 12'sd0, 1'b0, SS);
    send(8'sd41, 12'sd0, 1'b1, SS);
    checks++;
    if (level !== 3'd1 || data_out !== 8'sd41 || data_valid !== 1'b1) begin
      failures++;
      $display("FAIL level1_pop_capture got level=%0d out=%0d valid=%b exp 1/41/1", level, data_out, data_valid);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) send(8'sd50 + 8'(i), 12'sd0, 1'b0, SS);
    checks++;
    if (level !== 3'd3) begin
      failures++;
      $display("FAIL mid_fill got level=%0d exp 3", level);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (level !== 3'd0 || data_valid !== 1'b0 || data_out !== 8'sd0) begin
      failures++;
      $display("FAIL mid_reset got level=%0d valid=%b out=%0d exp 0/0/0", level, data_valid, data_out);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sweep();
    int cnt;
    bit found;
    logic signed [11:0] e [8];
    e = '{12'sd1, 12'sd2, 12'sd3, 12'sd4, 12'sd5, 12'sd6, 12'sd7, 12'sd99};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    cnt = 0;
    found = 1'b0;
    din1 = -12'sd2048;
    trigger_out = 1'b1;
    for (int i = 1; i <= int'(SS1) + 3 && !found; i++) begin
      tick();
      if (i == 2) trigger_out = 1'b0;
      if (valid1 === 1'b1) begin
        found = 1'b1;
        cnt = i;
      end
    end
    trigger_out = 1'b0;
    checks++;
    if (!found || cnt < int'(SS1) + 1) begin
      failures++;
      $display("FAIL wide_latency got found=%b cycles=%0d exp %0d..%0d", found, cnt, SS1 + 1, SS1 + 3);
    end
    checks++;
    if (dout1 !== -12'sd2048 || level1 !== 4'd1) begin
      failures++;
      $display("FAIL wide_min_value got out=%0d level=%0d exp -2048/1", dout1, level1);
    end
    for (int i = 0; i < 7; i++) send(8'sd0, e[i], 1'b0, SS1);
    checks++;
    if (level1 !== 4'd8 || ovf1 !== 1'b0) begin
      failures++;
      $display("FAIL wide_full got level=%0d ovf=%b exp 8/0", level1, ovf1);
    end
    send(8'sd0, 12'sd100, 1'b0, SS1);
    checks++;
    if (level1 !== 4'd8 || ovf1 !== 1'b1 || dout1 !== -12'sd2048) begin
      failures++;
      $display("FAIL wide_ovf got level=%0d ovf=%b head=%0d exp 8/1/-2048", level1, ovf1, dout1);
    end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    send(8'sd0, 12'sd99, 1'b1, SS1);
    checks++;
    if (level1 !== 4'd8 || ovf1 !== 1'b0) begin
      failures++;
      $display("FAIL wide_full_pop got level=%0d ovf=%b exp 8/0", level1, ovf1);
    end
    ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout1 !== e[i]) begin
        failures++;
        $display("FAIL wide_drain_%0d got out=%0d exp %0d", i, dout1, e[i]);
      end
      tick();
    end
    ready1 = 1'b0;
    checks++;
    if (valid1 !== 1'b0 || dout1 !== 12'sd99) begin
      failures++;
      $display("FAIL wide_drain_end got valid=%b out=%0d exp 0/99", valid1, dout1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
